// File: rtl/button_event_decoder.sv
`default_nettype none
// button_event_decoder: turns a debounced button level into one-cycle press/release/long/repeat strobes.
// Optional double-click detection on double_tick is enabled by defining BUTTON_DOUBLE_CLICK_EN.
module button_event_decoder #(
    parameter int  CLK_FREQ    = 100_000_000,
    parameter real LONG_TIME   = 1.0,
    parameter real REPEAT_TIME = 0.2,
    parameter real DOUBLE_TIME = 0.3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic db,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick,
    output logic repeat_tick,
    output logic double_tick,
    output logic held
);

    localparam int LONG_CYC   = $rtoi(CLK_FREQ * LONG_TIME);
    localparam int REPEAT_CYC = $rtoi(CLK_FREQ * REPEAT_TIME);
    localparam int DOUBLE_CYC = $rtoi(CLK_FREQ * DOUBLE_TIME);
    localparam int HOLD_MAX   = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int HOLD_W     = $clog2(HOLD_MAX + 1);

    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);

    if (LONG_CYC < 2) begin : g_bad_long
        $error("button_event_decoder: LONG_CYC must be >= 2");
    end
    if (REPEAT_CYC < 1) begin : g_bad_repeat
        $error("button_event_decoder: REPEAT_CYC must be >= 1");
    end
    if (DOUBLE_CYC < 1) begin : g_bad_double
        $error("button_event_decoder: DOUBLE_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;
    logic              db_q;
    logic              rise;
    logic              fall;
    logic              press_d;
    logic              release_d;
    logic              long_d;
    logic              repeat_d;
    logic              arm_req;

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            db_q         <= 1'b0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;
            repeat_tick  <= 1'b0;
            held         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            db_q         <= db;
            press_tick   <= press_d;
            release_tick <= release_d;
            long_tick    <= long_d;
            repeat_tick  <= repeat_d;
            held         <= (state_d != IDLE);
        end
    end

    // A fall always takes priority over a terminal count in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        arm_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    arm_req   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam int GAP_W = $clog2(DOUBLE_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DOUBLE_CYC - 1);

    logic             armed_q;
    logic [GAP_W-1:0] gap_q;

    // Window is armed only by a short-press release; a rise inside it beats expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q     <= 1'b0;
            gap_q       <= '0;
            double_tick <= 1'b0;
        end else begin
            double_tick <= press_d & armed_q;
            if (arm_req) begin
                armed_q <= 1'b1;
                gap_q   <= '0;
            end else if (armed_q) begin
                if (rise || (gap_q == GAP_LAST)) begin
                    armed_q <= 1'b0;
                    gap_q   <= '0;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
            end
        end
    end
`else
    logic unused_arm_req;
    assign unused_arm_req = arm_req;
    assign double_tick    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// Bench for button_event_decoder: vector table, directed corner cases, then random levels
// checked against an elapsed-time reference model.
module tb_button_event_decoder;

    localparam int LONG_N = 10;
    localparam int REP_N  = 4;
    localparam int DBL_N  = 6;
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    typedef struct {
        bit         d;
        logic [5:0] exp;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic db      = 1'b0;
    logic press_tick, release_tick, long_tick, repeat_tick, double_tick, held;
    logic [5:0] dut_o;
    logic [5:0] got;

    int total = 0;
    int bad   = 0;

    // reference model: previous level, held edges since press, window flag, low samples since release
    bit m_prev  = 1'b0;
    int m_n     = 0;
    bit m_armed = 1'b0;
    int m_lows  = 0;

    vec_t tbl[6];

    button_event_decoder #(
        .CLK_FREQ   (1000),
        .LONG_TIME  (0.010),
        .REPEAT_TIME(0.004),
        .DOUBLE_TIME(0.006)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .db          (db),
        .press_tick  (press_tick),
        .release_tick(release_tick),
        .long_tick   (long_tick),
        .repeat_tick (repeat_tick),
        .double_tick (double_tick),
        .held        (held)
    );

    assign dut_o = {press_tick, release_tick, long_tick, repeat_tick, double_tick, held};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {prs,rel,lng,rep,dbl,held}=%b want=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit d, output logic [5:0] e);
        bit p, r, l, rp, dbl;
        p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0; dbl = 1'b0;
        if (!m_prev && d) begin
            p       = 1'b1;
            dbl     = DBL_EN && m_armed && (m_lows <= DBL_N);
            m_armed = 1'b0;
            m_n     = 0;
        end else if (m_prev && !d) begin
            r       = 1'b1;
            m_armed = DBL_EN && (m_n < LONG_N);
            m_lows  = 1;
        end else if (m_prev) begin
            m_n++;
            l  = (m_n == LONG_N);
            rp = (m_n > LONG_N) && (((m_n - LONG_N) % REP_N) == 0);
        end else begin
            m_lows++;
        end
        m_prev = d;
        e = {p, r, l, rp, dbl, d};
    endtask

    // Starts and ends just after a falling edge; the next rising edge samples d.
    task automatic step(input bit d, input string name);
        logic [5:0] e;
        db = d;
        @(posedge clk);
        #1;
        model_edge(d, e);
        got = dut_o;
        check(name, got, e);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit d);
        reset_n = 1'b0;
        db      = d;
        #1;
        check("reset_async", dut_o, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", dut_o, 6'b0);
        @(negedge clk);
        reset_n = 1'b1;
        m_prev  = 1'b0;
        m_n     = 0;
        m_armed = 1'b0;
        m_lows  = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, "idle");
    endtask

    initial begin
        bit lvl;
        int len;

        tbl[0] = '{1'b0, 6'b000000};
        tbl[1] = '{1'b1, 6'b100001};
        tbl[2] = '{1'b1, 6'b000001};
        tbl[3] = '{1'b1, 6'b000001};
        tbl[4] = '{1'b0, 6'b010000};
        tbl[5] = '{1'b0, 6'b000000};

        @(negedge clk);
        do_reset(1'b0);

        // short press of three cycles
        foreach (tbl[i]) begin
            step(tbl[i].d, "t1_model");
            check($sformatf("t1_vec%0d", i), got, tbl[i].exp);
        end
        idle(8);

        // long hold with two repeats
        step(1'b1, "t2_model");
        check("t2_press", got, 6'b100001);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, "t2_model");
            check($sformatf("t2_hold%0d", i), got,
                  {2'b00, i == LONG_N, (i == LONG_N + REP_N) || (i == LONG_N + 2 * REP_N), 1'b0, 1'b1});
        end
        step(1'b0, "t2_model");
        check("t2_release", got, 6'b010000);
        idle(8);

        // fall coincides with the long terminal count
        step(1'b1, "t3_model");
        for (int i = 1; i < LONG_N; i++) begin
            step(1'b1, "t3_model");
            check($sformatf("t3_hold%0d", i), got, 6'b000001);
        end
        step(1'b0, "t3_model");
        check("t3_fall_wins", got, 6'b010000);
        idle(8);

        // reset mid-hold with the button still down
        step(1'b1, "t4_model");
        repeat (5) step(1'b1, "t4_model");
        do_reset(1'b1);
        step(1'b1, "t4_model");
        check("t4_post_reset_press", got, 6'b100001);
        step(1'b0, "t4_model");
        check("t4_release", got, 6'b010000);
        idle(8);

        // double-click window: gap 3 hits, gap 7 misses, long press never arms
        step(1'b1, "t5_model");
        check("t5_first_press", got, 6'b100001);
        step(1'b1, "t5_model");
        repeat (3) step(1'b0, "t5_model");
        step(1'b1, "t5_model");
        check("t5_gap3", got, {1'b1, 4'b0000, 1'b1} | {4'b0000, DBL_EN, 1'b0});
        step(1'b1, "t5_model");
        repeat (7) step(1'b0, "t5_model");
        step(1'b1, "t5_model");
        check("t5_gap7", got, 6'b100001);
        repeat (12) step(1'b1, "t5_model");
        repeat (3) step(1'b0, "t5_model");
        step(1'b1, "t5_model");
        check("t5_after_long", got, 6'b100001);
        step(1'b1, "t5_model");
        step(1'b0, "t5_model");
        check("t5_release", got, 6'b010000);
        idle(8);

        // random level runs, occasional reset
        lvl = 1'b0;
        for (int r = 0; r < 300; r++) begin
            lvl = ~lvl;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(LONG_N - 1, LONG_N + 3 * REP_N);
            else len = $urandom_range(1, DBL_N + 2);
            if ($urandom_range(0, 39) == 0) do_reset(lvl);
            for (int k = 0; k < len; k++) step(lvl, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
